// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
//   state_e : arbiter FSM states (IDLE, REQ, WAIT)
//   grant_e : which requester owns the current bus transaction
package mem_arb_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_e;

  // Byte-enable width for a given data width.
  function automatic int unsigned wen_width(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles for the arbiter's two sides.
//   mem_cpu_if : fetch (inst_*) and mem-stage (data_*) requests, done pulses,
//                read data and stall requests. master = pipeline, slave = arbiter.
//   mem_bus_if : SRAM-style bus with address phase (bus_req/bus_addr_ok) and
//                data phase (bus_data_ok/bus_rdata). master = arbiter, slave = memory.
interface mem_cpu_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);
  localparam int unsigned WW = wen_width(DW);

  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_done;
  logic          inst_stall;

  logic          data_req;
  logic          data_wr;
  logic [WW-1:0] data_wen;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_done;
  logic          data_stall;

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wen, data_addr, data_wdata,
    input  inst_rdata, inst_done, inst_stall,
    input  data_rdata, data_done, data_stall
  );

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wen, data_addr, data_wdata,
    output inst_rdata, inst_done, inst_stall,
    output data_rdata, data_done, data_stall
  );
endinterface

interface mem_bus_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);
  localparam int unsigned WW = wen_width(DW);

  logic          bus_req;
  logic          bus_wr;
  logic [WW-1:0] bus_wen;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_wen, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_wen, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Two-input fixed-priority picker (data over inst) with a per-input mask.
//   i_inst_req/i_data_req   : raw request levels
//   i_mask_inst/i_mask_data : suppress a request for this cycle
//   o_valid_c               : some unmasked request exists
//   o_grant_c               : winning side
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_inst_req,
  input  logic   i_data_req,
  input  logic   i_mask_inst,
  input  logic   i_mask_data,
  output logic   o_valid_c,
  output grant_e o_grant_c
);

  logic w_inst;
  logic w_data;

  always_comb begin
    w_inst    = i_inst_req & ~i_mask_inst;
    w_data    = i_data_req & ~i_mask_data;
    o_valid_c = w_inst | w_data;
    o_grant_c = w_data ? GNT_DATA : GNT_INST;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and mem-stage requests onto one SRAM-style bus, one
// transaction outstanding, data side first.
//   clk, rst : clock and synchronous active-high reset
//   cpu      : mem_cpu_if.slave  - requests in; done pulses, rdata, stalls out
//   bus      : mem_bus_if.master - bus address/data phases
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
)(
  input  logic      clk,
  input  logic      rst,
  mem_cpu_if.slave  cpu,
  mem_bus_if.master bus
);

  localparam int unsigned WW = wen_width(DW);

  state_e        r_state, w_state_nxt;
  grant_e        r_grant, w_grant_nxt;
  logic          r_wr,    w_wr_nxt;
  logic [WW-1:0] r_wen,   w_wen_nxt;
  logic [AW-1:0] r_addr,  w_addr_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;
  logic [DW-1:0] r_inst_rdata;
  logic [DW-1:0] r_data_rdata;

  logic          w_done;
  logic          w_inst_done;
  logic          w_data_done;
  logic          w_mask_inst;
  logic          w_mask_data;
  logic          w_pick_valid;
  grant_e        w_pick_grant;

  // Completion is only meaningful in WAIT; data_ok elsewhere is ignored.
  assign w_done      = (r_state == ST_WAIT) & bus.bus_data_ok;
  assign w_inst_done = w_done & (r_grant == GNT_INST);
  assign w_data_done = w_done & (r_grant == GNT_DATA);

  // The side completing this cycle still holds its request; mask it out.
  assign w_mask_inst = w_inst_done;
  assign w_mask_data = w_data_done;

  arb_pick u_pick (
    .i_inst_req  (cpu.inst_req),
    .i_data_req  (cpu.data_req),
    .i_mask_inst (w_mask_inst),
    .i_mask_data (w_mask_data),
    .o_valid_c   (w_pick_valid),
    .o_grant_c   (w_pick_grant)
  );

  // Next-state and latched bus fields.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_wr_nxt    = r_wr;
    w_wen_nxt   = r_wen;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.bus_addr_ok) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.bus_data_ok) begin
          w_state_nxt = w_pick_valid ? ST_REQ : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Capture the winner's fields whenever a new transaction is launched.
    if ((w_state_nxt == ST_REQ) && (r_state != ST_REQ)) begin
      w_grant_nxt = w_pick_grant;
      if (w_pick_grant == GNT_DATA) begin
        w_wr_nxt    = cpu.data_wr;
        w_wen_nxt   = cpu.data_wen;
        w_addr_nxt  = cpu.data_addr;
        w_wdata_nxt = cpu.data_wdata;
      end else begin
        w_wr_nxt    = 1'b0;
        w_wen_nxt   = '0;
        w_addr_nxt  = cpu.inst_addr;
        w_wdata_nxt = '0;
      end
    end
  end

  // State, latched fields and per-side read-data holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= GNT_INST;
      r_wr         <= 1'b0;
      r_wen        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_wr    <= w_wr_nxt;
      r_wen   <= w_wen_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      if (w_inst_done) begin
        r_inst_rdata <= bus.bus_rdata;
      end
      if (w_data_done && !r_wr) begin
        r_data_rdata <= bus.bus_rdata;
      end
    end
  end

  // Bus side.
  assign bus.bus_req   = (r_state == ST_REQ);
  assign bus.bus_wr    = r_wr;
  assign bus.bus_wen   = r_wen;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;

  // CPU side: done and read data pass through in the completion cycle.
  assign cpu.inst_done  = w_inst_done;
  assign cpu.data_done  = w_data_done;
  assign cpu.inst_rdata = w_inst_done ? bus.bus_rdata : r_inst_rdata;
  assign cpu.data_rdata = (w_data_done && !r_wr) ? bus.bus_rdata : r_data_rdata;
  assign cpu.inst_stall = cpu.inst_req & ~w_inst_done;
  assign cpu.data_stall = cpu.data_req & ~w_data_done;

endmodule
